wb_port_arbiter: RTL



---
 rtl/wb_port_arbiter_if.sv | 42 ++++
 rtl/wb_port_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter_if.sv
// Bundle between the function-unit result stages and the write-back arbiter:
// per-unit result requests in, two registered write-back ports out.
interface wb_port_arbiter_if #(
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32,
  parameter int WIN_W  = 4
);
  logic                  flush;
  logic [3:0]            req_valid;
  logic [4*TAG_W-1:0]    req_tag;
  logic [4*DATA_W-1:0]   req_data;
  logic [4*WIN_W-1:0]    req_win;
  logic [3:0]            req_ready;

  logic                  wb0_en;
  logic [TAG_W-1:0]      wb0_tag;
  logic [DATA_W-1:0]     wb0_data;
  logic [WIN_W-1:0]      wb0_win;
  logic [1:0]            wb0_src;
  logic                  wb1_en;
  logic [TAG_W-1:0]      wb1_tag;
  logic [DATA_W-1:0]     wb1_data;
  logic [WIN_W-1:0]      wb1_win;
  logic [1:0]            wb1_src;
  logic                  wb_pending;

  modport master (
    output flush, req_valid, req_tag, req_data, req_win,
    input  req_ready,
    input  wb0_en, wb0_tag, wb0_data, wb0_win, wb0_src,
    input  wb1_en, wb1_tag, wb1_data, wb1_win, wb1_src,
    input  wb_pending
  );

  modport slave (
    input  flush, req_valid, req_tag, req_data, req_win,
    output req_ready,
    output wb0_en, wb0_tag, wb0_data, wb0_win, wb0_src,
    output wb1_en, wb1_tag, wb1_data, wb1_win, wb1_src,
    output wb_pending
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares two write-back ports among ALU0/ALU1/BU/DU via per-unit FIFOs and a round-robin picker.
// Define WB_BYPASS_EN to let an empty unit's incoming result go straight to a write-back port.
module wb_port_arbiter #(
  parameter int TAG_W   = 6,
  parameter int DATA_W  = 32,
  parameter int WIN_W   = 4,
  parameter int Q_DEPTH = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  wb_port_arbiter_if.slave   bus
);
  localparam int NUM_LANES = 4;
  localparam int PTR_W     = $clog2(Q_DEPTH);
  localparam int CNT_W     = PTR_W + 1;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic [WIN_W-1:0]  win;
  } ent_t;

  typedef struct packed {
    logic              en;
    ent_t              ent;
    logic [1:0]        src;
  } wb_t;

  ent_t [NUM_LANES-1:0] in_ent;
  ent_t [NUM_LANES-1:0] head;
  logic [NUM_LANES-1:0] nonempty, byp, cand, grant;

  logic [1:0] rr_q, rr_d;
  logic [1:0] g0_id, g1_id, idx;
  logic       g0_vld, g1_vld;
  wb_t        wb0_q, wb0_d, wb1_q, wb1_d;
  logic       clr;

  assign clr = !rst_ni || bus.flush;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [CNT_W-1:0]          cnt_q;
    logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q;
    ent_t [Q_DEPTH-1:0]        mem_q;
    logic                      push, pop;

    assign in_ent[i] = '{tag:  bus.req_tag[i*TAG_W +: TAG_W],
                         data: bus.req_data[i*DATA_W +: DATA_W],
                         win:  bus.req_win[i*WIN_W +: WIN_W]};

    assign nonempty[i]      = cnt_q != '0;
    assign bus.req_ready[i] = cnt_q != CNT_W'(Q_DEPTH);
`ifdef WB_BYPASS_EN
    assign byp[i] = !nonempty[i] && bus.req_valid[i];
`else
    assign byp[i] = 1'b0;
`endif
    assign cand[i] = nonempty[i] | byp[i];
    assign head[i] = nonempty[i] ? mem_q[rd_ptr_q] : in_ent[i];

    // A bypassed result is consumed by the port register and never stored.
    assign pop  = grant[i] & nonempty[i];
    assign push = bus.req_valid[i] & bus.req_ready[i] & ~(grant[i] & byp[i]);

    always_ff @(posedge clk_i) begin
      if (clr) begin
        cnt_q    <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) begin
          mem_q[wr_ptr_q] <= in_ent[i];
          wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Rotating scan from rr_q: first candidate takes port 0, second takes port 1.
  always_comb begin
    g0_vld = 1'b0;
    g1_vld = 1'b0;
    g0_id  = '0;
    g1_id  = '0;
    grant  = '0;
    idx    = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      idx = rr_q + 2'(k);
      if (cand[idx]) begin
        if (!g0_vld) begin
          g0_vld     = 1'b1;
          g0_id      = idx;
          grant[idx] = 1'b1;
        end else if (!g1_vld) begin
          g1_vld     = 1'b1;
          g1_id      = idx;
          grant[idx] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    wb0_d = '0;
    wb1_d = '0;
    rr_d  = rr_q;
    if (g0_vld) wb0_d = '{en: 1'b1, ent: head[g0_id], src: g0_id};
    if (g1_vld) wb1_d = '{en: 1'b1, ent: head[g1_id], src: g1_id};
    if (g1_vld)      rr_d = g1_id + 2'd1;
    else if (g0_vld) rr_d = g0_id + 2'd1;
  end

  // Flush clears results but keeps the fairness pointer where it was.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q  <= '0;
      wb0_q <= '0;
      wb1_q <= '0;
    end else if (bus.flush) begin
      wb0_q <= '0;
      wb1_q <= '0;
    end else begin
      rr_q  <= rr_d;
      wb0_q <= wb0_d;
      wb1_q <= wb1_d;
    end
  end

  assign bus.wb0_en     = wb0_q.en;
  assign bus.wb0_tag    = wb0_q.ent.tag;
  assign bus.wb0_data   = wb0_q.ent.data;
  assign bus.wb0_win    = wb0_q.ent.win;
  assign bus.wb0_src    = wb0_q.src;
  assign bus.wb1_en     = wb1_q.en;
  assign bus.wb1_tag    = wb1_q.ent.tag;
  assign bus.wb1_data   = wb1_q.ent.data;
  assign bus.wb1_win    = wb1_q.ent.win;
  assign bus.wb1_src    = wb1_q.src;
  assign bus.wb_pending = |nonempty;
endmodule
